gb_byte_host: RTL and testbench

- Host-side master for the ghostbus. Converts a framed byte stream (valid/ready, e.g. from a UART or USB FIFO) into single-cycle ghostbus write strobes and fixed-latency reads.
- Drives gb_addr/gb_wdata/gb_wen/gb_rstb into the ghostbus decode network and samples gb_rdata. Returns read data and write acks as a byte stream.

---
 rtl/gb_byte_host_if.sv | 28 ++
 rtl/gb_byte_host.sv | 162 ++++++++++++++++
 tb/tb_gb_byte_host.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_byte_host_if.sv
// Byte-stream and ghostbus signal bundle for the ghostbus host master.
// master = the host block, slave = the byte source/sink and decode network.
interface gb_byte_host_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic [DW-1:0] gb_rdata;
  logic          gb_wen;
  logic          gb_rstb;

  modport master (
    input  rx_data, rx_valid, tx_ready, gb_rdata,
    output rx_ready, tx_data, tx_valid, gb_addr, gb_wdata, gb_wen, gb_rstb
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, gb_rdata,
    input  rx_ready, tx_data, tx_valid, gb_addr, gb_wdata, gb_wen, gb_rstb
  );
endinterface

// File: rtl/gb_byte_host.sv
// Ghostbus host master: framed byte stream in, single-cycle write strobes and
// fixed-latency reads out, write acks and read data returned as bytes.
module gb_byte_host #(
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD     = 8,
  parameter logic [7:0]  WR_ACK = 8'hAC
) (
  input  logic           clk,
  input  logic           rst_n,
  gb_byte_host_if.master bus,
  output logic           busy,
  output logic           err
);

  localparam int unsigned AB = AW / 8;
  localparam int unsigned DB = DW / 8;
  localparam int unsigned CW = 8;
  localparam logic [7:0]  CMD_WR = 8'h01;
  localparam logic [7:0]  CMD_RD = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WSTB, S_RSTB, S_RWAIT, S_TXACK, S_TXRD
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rsh_q, rsh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          wen_q, wen_d;
  logic          rstb_q, rstb_d;
  logic          busy_d, err_d;
  logic          rx_ready_q, rx_ready_d;
  logic          rx_fire, tx_fire;

  assign rx_fire = bus.rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & bus.tx_ready;

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.gb_addr  = addr_q;
  assign bus.gb_wdata = wdata_q;
  assign bus.gb_wen   = wen_q;
  assign bus.gb_rstb  = rstb_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_fire && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) state_d = S_ADDR;
      S_ADDR:  if (rx_fire && cnt_q == CW'(AB - 1)) state_d = is_wr_q ? S_DATA : S_RSTB;
      S_DATA:  if (rx_fire && cnt_q == CW'(DB - 1)) state_d = S_WSTB;
      S_WSTB:  state_d = S_TXACK;
      S_RSTB:  state_d = S_RWAIT;
      S_RWAIT: if (cnt_q == CW'(1)) state_d = S_TXRD;
      S_TXACK: if (tx_fire) state_d = S_IDLE;
      S_TXRD:  if (tx_fire && cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered from these
  always_comb begin
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    rsh_d      = rsh_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    wen_d      = (state_d == S_WSTB);
    rstb_d     = (state_d == S_RSTB);
    busy_d     = (state_d != S_IDLE);
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    case (state_q)
      S_IDLE: if (rx_fire) begin
        is_wr_d = (bus.rx_data == CMD_WR);
        cnt_d   = '0;
        err_d   = (state_d == S_IDLE);
      end
      S_ADDR: if (rx_fire) begin
        addr_d = AW'({addr_q, bus.rx_data});
        cnt_d  = (state_d == S_ADDR) ? cnt_q + CW'(1) : '0;
      end
      S_DATA: if (rx_fire) begin
        wdata_d = DW'({wdata_q, bus.rx_data});
        cnt_d   = (state_d == S_DATA) ? cnt_q + CW'(1) : '0;
      end
      S_WSTB: begin
        tx_data_d  = WR_ACK;
        tx_valid_d = 1'b1;
      end
      S_RSTB: cnt_d = CW'(RD);
      S_RWAIT: begin
        // Capture on the edge ending cycle rstb+RD, first byte goes straight out
        if (state_d == S_TXRD) begin
          tx_data_d  = bus.gb_rdata[DW-1 -: 8];
          rsh_d      = DW'({bus.gb_rdata, 8'h00});
          tx_valid_d = 1'b1;
          cnt_d      = CW'(DB - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TXACK: if (tx_fire) tx_valid_d = 1'b0;
      S_TXRD: if (tx_fire) begin
        if (cnt_q == '0) begin
          tx_valid_d = 1'b0;
        end else begin
          tx_data_d = rsh_q[DW-1 -: 8];
          rsh_d     = DW'({rsh_q, 8'h00});
          cnt_d     = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      rsh_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wen_q      <= 1'b0;
      rstb_q     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      rsh_q      <= rsh_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wen_q      <= wen_d;
      rstb_q     <= rstb_d;
      busy       <= busy_d;
      err        <= err_d;
      rx_ready_q <= rx_ready_d;
    end
  end

endmodule

// File: tb/tb_gb_byte_host.sv
// Scoreboard bench for gb_byte_host: three instances (RD=8,1,3) share the
// stimulus; only the selected instance sees rx_valid.
module tb_gb_byte_host;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;

  typedef struct { logic [7:0] d; bit last; } tx_exp_t;
  typedef struct { logic [23:0] a; logic [31:0] d; } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [31:0] rd_val = '0;
  int          sel = 0;
  int          cyc = 0;
  bit          tx_mode = 0;
  bit          drv_cmd = 0;
  int          ph = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;
  int err_exp  = 0;

  tx_exp_t exp_tx[$];
  wr_exp_t exp_wr[$];

  logic        a_rx_ready[3];
  logic [7:0]  a_tx_data[3];
  logic        a_tx_valid[3];
  logic [23:0] a_addr[3];
  logic [31:0] a_wdata[3];
  logic        a_wen[3];
  logic        a_rstb[3];
  logic        a_busy[3];
  logic        a_err[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready: always 1, or the 1,0,0 backpressure pattern
  always @(posedge clk) begin
    #1;
    tx_ready = tx_mode ? (ph == 0) : 1'b1;
    ph = (ph == 2) ? 0 : ph + 1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned RDG = (g == 0) ? 8 : (g == 1) ? 1 : 3;
    gb_byte_host_if #(.AW(AW), .DW(DW)) bus ();
    logic [7:0] lat;
    logic       busy, err;

    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid && (sel == g);
    assign bus.tx_ready = tx_ready;
    // Read data is valid only in cycle rstb+RD; garbage otherwise
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lat <= '0;
      else if (bus.gb_rstb) lat <= 8'(RDG);
      else if (lat != 0) lat <= lat - 8'd1;
    end
    assign bus.gb_rdata = (lat == 8'd1) ? rd_val : (32'hA5A5_0000 | 32'(cyc[15:0]));

    gb_byte_host #(.AW(AW), .DW(DW), .RD(RDG), .WR_ACK(8'hAC)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err)
    );

    assign a_rx_ready[g] = bus.rx_ready;
    assign a_tx_data[g]  = bus.tx_data;
    assign a_tx_valid[g] = bus.tx_valid;
    assign a_addr[g]     = bus.gb_addr;
    assign a_wdata[g]    = bus.gb_wdata;
    assign a_wen[g]      = bus.gb_wen;
    assign a_rstb[g]     = bus.gb_rstb;
    assign a_busy[g]     = busy;
    assign a_err[g]      = err;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input int g);
    chk("rst_rx_ready", 64'(a_rx_ready[g]), 0);
    chk("rst_tx_valid", 64'(a_tx_valid[g]), 0);
    chk("rst_tx_data",  64'(a_tx_data[g]), 0);
    chk("rst_gb_addr",  64'(a_addr[g]), 0);
    chk("rst_gb_wdata", 64'(a_wdata[g]), 0);
    chk("rst_gb_wen",   64'(a_wen[g]), 0);
    chk("rst_gb_rstb",  64'(a_rstb[g]), 0);
    chk("rst_busy",     64'(a_busy[g]), 0);
    chk("rst_err",      64'(a_err[g]), 0);
  endtask

  // Monitor / scoreboard
  bit         hold_v = 0;
  logic [7:0] hold_d = '0;
  bit         in_frame = 0;
  bit         busy_bad = 0;
  tx_exp_t    mon_e;
  wr_exp_t    mon_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
      in_frame = 0;
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (a_wen[g]) begin
          if (exp_wr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_wen: dut %0d addr %0h data %0h, expected no strobe", g, a_addr[g], a_wdata[g]);
          end else begin
            mon_w = exp_wr.pop_front();
            chk("wen_addr", 64'(a_addr[g]), 64'(mon_w.a));
            chk("wen_data", 64'(a_wdata[g]), 64'(mon_w.d));
          end
        end
      end
      if (a_err[sel]) err_seen++;
      if (hold_v) begin
        chk("tx_hold_valid", 64'(a_tx_valid[sel]), 1);
        chk("tx_hold_data", 64'(a_tx_data[sel]), 64'(hold_d));
      end
      hold_v = a_tx_valid[sel] && !tx_ready;
      hold_d = a_tx_data[sel];
      if (in_frame && !a_busy[sel]) busy_bad = 1;
      if (a_tx_valid[sel] && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_tx: got %0h, expected no byte", a_tx_data[sel]);
        end else begin
          mon_e = exp_tx.pop_front();
          chk("tx_byte", 64'(a_tx_data[sel]), 64'(mon_e.d));
          if (mon_e.last && in_frame) begin
            chk("busy_span", 64'(busy_bad), 0);
            in_frame = 0;
          end
        end
      end
      if (drv_cmd && rx_valid && a_rx_ready[sel]) begin
        in_frame = 1;
        busy_bad = 0;
      end
    end
  end

  // Present one byte after 0..gmax idle cycles and wait for the handshake
  task automatic put_byte(input logic [7:0] b, input int gmax, input bit is_cmd);
    int gap;
    int t;
    bit ok;
    gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b; rx_valid = 1'b1; drv_cmd = is_cmd;
    t = 0; ok = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = a_rx_ready[sel];
      @(posedge clk); #1;
      t++;
    end
    rx_valid = 1'b0; drv_cmd = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL rx_timeout: byte %0h not accepted, expected acceptance within 200 cycles", b);
    end
  endtask

  task automatic send_write(input logic [23:0] addr, input logic [31:0] data, input int gmax);
    exp_wr.push_back('{a: addr, d: data});
    exp_tx.push_back('{d: 8'hAC, last: 1'b1});
    put_byte(8'h01, gmax, 1'b1);
    for (int i = 2; i >= 0; i--) put_byte(addr[i*8 +: 8], gmax, 1'b0);
    for (int i = 3; i >= 0; i--) put_byte(data[i*8 +: 8], gmax, 1'b0);
  endtask

  task automatic send_read(input logic [23:0] addr, input logic [31:0] val, input int gmax);
    rd_val = val;
    for (int i = 3; i >= 0; i--) exp_tx.push_back('{d: val[i*8 +: 8], last: (i == 0)});
    put_byte(8'h02, gmax, 1'b1);
    for (int i = 2; i >= 0; i--) put_byte(addr[i*8 +: 8], gmax, 1'b0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: %0d tx and %0d writes outstanding, expected 0", exp_tx.size(), exp_wr.size());
      exp_tx.delete(); exp_wr.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state of every instance
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk_reset(g);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_before_edge", 64'(a_rx_ready[0]), 0);
    @(negedge clk);
    chk("rx_ready_after_edge", 64'(a_rx_ready[0]), 1);
    @(posedge clk); #1;

    // Plain write, then hold of addr/wdata in IDLE
    send_write(24'h123456, 32'hDEADBEEF, 0);
    wait_done();
    @(negedge clk);
    chk("addr_hold", 64'(a_addr[0]), 64'h123456);
    chk("wdata_hold", 64'(a_wdata[0]), 64'hDEADBEEF);
    @(posedge clk); #1;

    // Read latency RD=8, 1, 3
    for (int g = 0; g < 3; g++) begin
      sel = g;
      send_read(24'h000040, 32'h00000042, 0);
      wait_done();
    end
    sel = 0;

    // Backpressure on read and write
    tx_mode = 1;
    send_read(24'hABCDEF, 32'hCAFEF00D, 0);
    wait_done();
    send_write(24'h00BEEF, 32'h01020304, 0);
    wait_done();
    tx_mode = 0;

    // Illegal command followed by a normal write
    put_byte(8'h7F, 0, 1'b0);
    err_exp++;
    @(negedge clk);
    chk("err_pulse", 64'(a_err[0]), 1);
    chk("err_busy", 64'(a_busy[0]), 0);
    chk("err_rx_ready", 64'(a_rx_ready[0]), 1);
    @(negedge clk);
    chk("err_one_cycle", 64'(a_err[0]), 0);
    @(posedge clk); #1;
    send_write(24'h000001, 32'h00000005, 0);
    wait_done();

    // Reset mid-frame, then a read
    put_byte(8'h01, 0, 1'b1);
    put_byte(8'h12, 0, 1'b0);
    put_byte(8'h34, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset(0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_read(24'h000000, 32'h1234ABCD, 0);
    wait_done();

    // Random rx gaps inside frames, with and without backpressure
    send_write(24'h123456, 32'hDEADBEEF, 5);
    wait_done();
    send_read(24'h000040, 32'h00000042, 5);
    wait_done();
    sel = 2;
    send_read(24'h00A5A5, 32'h89ABCDEF, 5);
    wait_done();
    sel = 0;
    tx_mode = 1;
    send_write(24'hFEDCBA, 32'h55AA33CC, 5);
    wait_done();
    tx_mode = 0;

    chk("err_pulse_count", 64'(err_seen), 64'(err_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
